// File: rtl/avalon_reg_bank.sv
// Byte-addressable control/status register bank behind an Avalon-MM slave port,
// with a hardware full-word load port, per-register write pulses and a write counter.
module avalon_reg_bank #(
  parameter int                 DATA_W    = 32,
  parameter int                 NUM_REGS  = 8,
  parameter int                 ADDR_W    = 3,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            address,
  input  logic                         write,
  input  logic [DATA_W-1:0]            writedata,
  input  logic [DATA_W/8-1:0]          byteenable,
  input  logic                         read,
  output logic [DATA_W-1:0]            readdata,
  output logic                         readdatavalid,
  input  logic                         hw_we,
  input  logic [ADDR_W-1:0]            hw_addr,
  input  logic [DATA_W-1:0]            hw_data,
  output logic [NUM_REGS*DATA_W-1:0]   q,
  output logic [NUM_REGS-1:0]          wr_pulse,
  output logic [15:0]                  wr_count
);

  localparam int                NUM_LANES  = DATA_W / 8;
  localparam int                AW1        = ADDR_W + 1;
  localparam logic [ADDR_W:0]   NUM_REGS_L = AW1'(NUM_REGS);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [DATA_W-1:0]   readdata_q, readdata_d;
  logic                readdatavalid_q, readdatavalid_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [15:0]         wr_count_q, wr_count_d;

  logic                addr_in_range;
  logic                bus_wr_ok;
  logic [DATA_W-1:0]   rd_val;

  assign addr_in_range = ({1'b0, address} < NUM_REGS_L);
  assign bus_wr_ok     = write && addr_in_range && (byteenable != '0);

  // Decoding by comparison keeps out-of-range addresses from ever indexing the array.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if ({1'b0, address} == AW1'(i)) rd_val = regs_q[i];
    end
  end

  // hw load lands first so that bus-enabled lanes win on a same-register collision.
  always_comb begin
    wr_pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (hw_we && ({1'b0, hw_addr} == AW1'(i))) regs_d[i] = hw_data;
      if (bus_wr_ok && ({1'b0, address} == AW1'(i))) begin
        wr_pulse_d[i] = 1'b1;
        for (int b = 0; b < NUM_LANES; b++) begin
          if (byteenable[b]) regs_d[i][8*b +: 8] = writedata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (bus_wr_ok) wr_count_d = wr_count_q + 16'd1;
  end

  // Read samples the pre-update contents, giving read-before-write on a shared edge.
  always_comb begin
    readdatavalid_d = read;
    readdata_d      = readdata_q;
    if (read) readdata_d = rd_val;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      wr_pulse_q      <= '0;
      wr_count_q      <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
      wr_pulse_q      <= wr_pulse_d;
      wr_count_q      <= wr_count_d;
    end
  end

  always_comb begin
    q = '0;
    for (int i = 0; i < NUM_REGS; i++) q[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;
  assign wr_pulse      = wr_pulse_q;
  assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_avalon_reg_bank.sv
// Bench for avalon_reg_bank (6 registers on a 3-bit address) against a per-edge reference model.
module tb_avalon_reg_bank;

  localparam int DW = 32;
  localparam int NR = 6;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   address;
  logic            write;
  logic [DW-1:0]   writedata;
  logic [DW/8-1:0] byteenable;
  logic            read;
  logic [DW-1:0]   readdata;
  logic            readdatavalid;
  logic            hw_we;
  logic [AW-1:0]   hw_addr;
  logic [DW-1:0]   hw_data;
  logic [NR*DW-1:0] q;
  logic [NR-1:0]   wr_pulse;
  logic [15:0]     wr_count;

  avalon_reg_bank #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .RESET_VAL(32'h0)) dut (
    .clock(clk), .reset(reset), .address(address), .write(write),
    .writedata(writedata), .byteenable(byteenable), .read(read),
    .readdata(readdata), .readdatavalid(readdatavalid), .hw_we(hw_we),
    .hw_addr(hw_addr), .hw_data(hw_data), .q(q), .wr_pulse(wr_pulse),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  logic [31:0] m_regs [NR];
  logic [31:0] m_rd;
  logic        m_rdv;
  logic [NR-1:0] m_pulse;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: one call per clock edge, using the inputs present at that edge.
  task automatic model_edge();
    int a, h;
    logic [31:0] mask;
    a = int'(address);
    h = int'(hw_addr);
    if (reset) begin
      for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
      m_rd = 0; m_rdv = 0; m_pulse = 0; m_cnt = 0;
    end else begin
      m_rdv = read;
      if (read) m_rd = (a < NR) ? m_regs[a] : 32'h0;
      m_pulse = 0;
      if (hw_we && h < NR) m_regs[h] = hw_data;
      if (write && a < NR && byteenable != 0) begin
        mask = 0;
        for (int k = 0; k < 4; k++) if (byteenable[k]) mask = mask | (32'hFF << (8 * k));
        m_regs[a] = (m_regs[a] & ~mask) | (writedata & mask);
        m_pulse[a] = 1'b1;
        m_cnt = m_cnt + 16'd1;
      end
    end
  endtask

  task automatic check_all();
    logic [NR*DW-1:0] eq;
    for (int i = 0; i < NR; i++) eq[i*DW +: DW] = m_regs[i];
    chk("q", 256'(q), 256'(eq));
    chk("readdata", 256'(readdata), 256'(m_rd));
    chk("readdatavalid", 256'(readdatavalid), 256'(m_rdv));
    chk("wr_pulse", 256'(wr_pulse), 256'(m_pulse));
    chk("wr_count", 256'(wr_count), 256'(m_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    reset = 0; write = 0; read = 0; hw_we = 0;
    address = 0; writedata = 0; byteenable = 0; hw_addr = 0; hw_data = 0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
    m_rd = 0; m_rdv = 0; m_pulse = 0; m_cnt = 0;
    idle();
    reset = 1;
    step();
    chk("reset_count", 256'(wr_count), 256'(16'h0));
    chk("reset_rdv", 256'(readdatavalid), 256'(1'b0));
    idle();

    // back-to-back reads of every address
    for (int i = 0; i < 8; i++) begin
      read = 1; address = AW'(i);
      step();
      chk("bb_rdv", 256'(readdatavalid), 256'(1'b1));
      chk("bb_rdata", 256'(readdata), 256'(32'h0));
    end
    idle();

    // full write then sparse-lane write to reg 2
    write = 1; address = 2; writedata = 32'hDEADBEEF; byteenable = 4'hF;
    step();
    chk("pulse2_a", 256'(wr_pulse[2]), 256'(1'b1));
    writedata = 32'h11223344; byteenable = 4'b0101;
    step();
    chk("pulse2_b", 256'(wr_pulse[2]), 256'(1'b1));
    chk("reg2_val", 256'(q[2*DW +: DW]), 256'(32'hDE22BE44));
    chk("count2", 256'(wr_count), 256'(16'd2));
    idle();
    step();
    chk("pulse2_off", 256'(wr_pulse), 256'(6'b0));

    // rejected writes: out-of-range address, then zero byteenable
    write = 1; address = 7; writedata = 32'hFFFFFFFF; byteenable = 4'hF;
    step();
    chk("oor_pulse", 256'(wr_pulse), 256'(6'b0));
    chk("oor_count", 256'(wr_count), 256'(16'd2));
    address = 1; byteenable = 4'h0;
    step();
    chk("be0_pulse", 256'(wr_pulse), 256'(6'b0));
    chk("be0_count", 256'(wr_count), 256'(16'd2));
    idle();
    read = 1; address = 7;
    step();
    chk("oor_rdata", 256'(readdata), 256'(32'h0));
    chk("oor_rdv", 256'(readdatavalid), 256'(1'b1));
    idle();

    // hw load and bus write collide on reg 1
    hw_we = 1; hw_addr = 1; hw_data = 32'hAAAAAAAA;
    write = 1; address = 1; writedata = 32'h55555555; byteenable = 4'b0011;
    step();
    chk("coll_reg1", 256'(q[1*DW +: DW]), 256'(32'hAAAA5555));
    chk("coll_pulse1", 256'(wr_pulse[1]), 256'(1'b1));
    chk("coll_count", 256'(wr_count), 256'(16'd3));
    idle();

    // read-before-write on reg 3
    read = 1; write = 1; address = 3; writedata = 32'h12345678; byteenable = 4'hF;
    step();
    chk("rbw_rdata", 256'(readdata), 256'(32'h0));
    idle();
    step();
    chk("rbw_reg3", 256'(q[3*DW +: DW]), 256'(32'h12345678));

    // randomized traffic including rejected writes and hw loads
    for (int n = 0; n < 400; n++) begin
      address = AW'($urandom_range(0, 7));
      write = 1'($urandom_range(0, 1));
      writedata = $urandom;
      byteenable = 4'($urandom_range(0, 15));
      read = 1'($urandom_range(0, 1));
      hw_we = 1'($urandom_range(0, 1));
      hw_addr = AW'($urandom_range(0, 7));
      hw_data = $urandom;
      step();
    end
    idle();

    // counter wrap after 65536 accepted writes
    reset = 1;
    step();
    reset = 0;
    for (int n = 0; n < 65536; n++) begin
      write = 1;
      address = AW'($urandom_range(0, NR - 1));
      byteenable = 4'($urandom_range(1, 15));
      writedata = $urandom;
      read = 1'($urandom_range(0, 1));
      hw_we = 1'($urandom_range(0, 1));
      hw_addr = AW'($urandom_range(0, 7));
      hw_data = $urandom;
      step();
      if (n == 65534) chk("count_ffff", 256'(wr_count), 256'(16'hFFFF));
    end
    chk("count_wrap", 256'(wr_count), 256'(16'h0));
    idle();

    // reset asserted during a read, with a valid already pending
    read = 1; address = 2;
    step();
    chk("pre_rst_rdv", 256'(readdatavalid), 256'(1'b1));
    reset = 1; write = 1; writedata = 32'hCAFEF00D; byteenable = 4'hF;
    hw_we = 1; hw_addr = 4; hw_data = 32'h0BADBEEF;
    step();
    chk("rst_rdv", 256'(readdatavalid), 256'(1'b0));
    chk("rst_rdata", 256'(readdata), 256'(32'h0));
    chk("rst_q", 256'(q), 256'(0));
    chk("rst_pulse", 256'(wr_pulse), 256'(6'b0));
    chk("rst_count", 256'(wr_count), 256'(16'h0));
    idle();
    step();
    chk("post_rst_rdv", 256'(readdatavalid), 256'(1'b0));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/avalon_reg_bank.md
# avalon_reg_bank

Parametrised bank of byte-addressable control/status registers behind an Avalon-MM slave port, the general successor to the team's single 32-bit byte-enable register. Every byteenable pattern is supported, not only the aligned 8/16/32-bit subset. Reads are registered with a `readdatavalid` strobe. A hardware-side load port lets the datapath update any register. Per-register write pulses and a bus-write counter feed the peripheral's interrupt and debug logic.

## Interface
- `DATA_W`, 32: register width in bits; must be a multiple of 8.
- `NUM_REGS`, 8: number of registers; range 1..2^ADDR_W.
- `ADDR_W`, 3: word-address width; must be ≥1.
- `RESET_VAL`, 0: value loaded into every register on reset (DATA_W bits).

- `clock`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  ADDR_W  word address for the bus access.
- `write`  in  1  bus write request; single-cycle; no waitrequest.
- `writedata`  in  DATA_W  bus write data.
- `byteenable`  in  DATA_W/8  per-byte-lane write enable; bit k covers `writedata[8k+7:8k]`.
- `read`  in  1  bus read request; single-cycle.
- `readdata`  out  DATA_W  registered read data.
- `readdatavalid`  out  1  high for one cycle when `readdata` is valid.
- `hw_we`  in  1  hardware full-word load strobe.
- `hw_addr`  in  ADDR_W  hardware load target.
- `hw_data`  in  DATA_W  hardware load data.
- `q`  out  NUM_REGS*DATA_W  all register contents, flattened; register i occupies `q[i*DATA_W +: DATA_W]`.
- `wr_pulse`  out  NUM_REGS  one-cycle pulse per register accepted by a bus write.
- `wr_count`  out  16  count of accepted bus writes; wraps.

## Operation
- Reset: when `reset` is high at an edge, the following values load:
  - every register ← RESET_VAL;
  - `readdata` ← 0, `readdatavalid` ← 0;
  - `wr_pulse` ← 0, `wr_count` ← 0.
- Reset overrides any simultaneous write, read or hw load.
- A bus write is accepted when all hold: `write`=1, `address` < NUM_REGS, and `byteenable` ≠ 0.
  - Only enabled byte lanes change; disabled lanes hold their value.
  - Any lane pattern is legal, e.g. 4'b0101 or 4'b0110.
- Rejected writes have no effect: no register change, no `wr_pulse`, no count. Out-of-range addresses and all-zero byteenable are rejected silently.
- Hardware load: `hw_we`=1 with `hw_addr` < NUM_REGS replaces the whole word. Out-of-range `hw_addr` is ignored.
- Same-cycle collision on one register: the hw load applies first, then the bus-enabled lanes overwrite it.
  - Result per lane: bus data where `byteenable` is set, otherwise `hw_data`.
- Collision on different registers: both updates apply independently.
- Hardware loads never assert `wr_pulse` and never increment `wr_count`.
- Read: `read`=1 captures the register value into `readdata` and sets `readdatavalid` for exactly one cycle.
  - The captured value is the content before any same-edge update: read-before-write.
  - If `address` ≥ NUM_REGS, `readdata` is 0 and `readdatavalid` still asserts.
- Without a read, `readdata` holds its last value and `readdatavalid` is 0.
- `read` and `write` asserted together are both serviced.
- `wr_count`: +1 per accepted bus write; 16'hFFFF wraps to 0.

## Timing
- Write latency: a write sampled at edge N is visible on `q` from edge N onward (same cycle `wr_pulse` is high).
- `wr_pulse[i]` is registered: high for exactly the cycle after edge N, then low unless another write to i is accepted.
  - Back-to-back writes to the same register keep the pulse high continuously.
- `wr_count` updates at the same edge as the write.
- Read latency is fixed at 1: `read` at edge N gives `readdatavalid`/`readdata` after edge N.
- One read per cycle is supported with no bubbles.
- Reset mid-stream:
  - a read in the reset cycle produces no `readdatavalid`;
  - a `readdatavalid` pending from the prior edge is cleared at the reset edge.
- No combinational path from any input to any output.

## Test plan
- Reset, then read all NUM_REGS addresses back-to-back.
  - Required: eight consecutive `readdatavalid` cycles, each returning RESET_VAL.
  - Required: `wr_count`=0.
- Write 32'hDEADBEEF to reg 2 with byteenable 4'hF, then 32'h11223344 with 4'b0101.
  - Required: `q` reg2 = 32'hDE22BE44.
  - Required: `wr_pulse[2]` high for 2 cycles, `wr_count`=2.
- Write to address 7 with NUM_REGS=6, then a write with byteenable 0.
  - Required: no register change, `wr_pulse`=0, `wr_count` unchanged.
  - Required: a read of address 7 returns 0 with `readdatavalid`=1.
- Same cycle to reg 1: `hw_we` with `hw_data` 32'hAAAAAAAA, plus a bus write of 32'h55555555 with byteenable 4'b0011.
  - Required: reg1 = 32'hAAAA5555.
  - Required: `wr_pulse[1]`=1, `wr_count` +1.
- Read reg 3 and write 32'h12345678 (4'hF) to reg 3 in the same cycle, with reg 3 previously 0.
  - Required: `readdata`=0, and reg3 = 32'h12345678 the next cycle.
- Issue 65536 accepted writes, asserting reset during a read.
  - Required: `wr_count` wraps to 0.
  - Required: at the reset edge, every output returns to its reset value and no `readdatavalid` is produced.
